// File: rtl/tm_lif_core.sv
// Time-multiplexed leaky integrate-and-fire core: one neuron is updated per accepted input.
// Optional refractory counters are built when TM_LIF_REFRACTORY_EN is defined.
module tm_lif_core #(
    parameter int N_NEURONS  = 8,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int THRESH_RST = 127,
    parameter int REFRAC_CYC = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_current,
    input  logic                         cfg_we,
    input  logic [$clog2(N_NEURONS)-1:0] cfg_addr,
    input  logic [W-1:0]                 cfg_thresh,
    output logic                         spike_valid,
    output logic                         spike,
    output logic [$clog2(N_NEURONS)-1:0] spike_id,
    output logic [W-1:0]                 state_out,
    output logic [N_NEURONS-1:0]         spike_vec,
    output logic                         frame_done
);

    localparam int AW = $clog2(N_NEURONS);
    localparam logic [W-1:0]  THRESH_INIT = W'(THRESH_RST);
    localparam logic [AW-1:0] LAST_IDX    = AW'(N_NEURONS - 1);

    if (N_NEURONS < 2 || N_NEURONS > 64 || (1 << AW) != N_NEURONS) begin : g_bad_n
        $error("tm_lif_core: N_NEURONS must be a power of two in 2..64");
    end
    if (LEAK_SHIFT < 0 || LEAK_SHIFT >= W) begin : g_bad_leak
        $error("tm_lif_core: LEAK_SHIFT must be in 0..W-1");
    end
    if (REFRAC_CYC < 1 || REFRAC_CYC > 15) begin : g_bad_refrac
        $error("tm_lif_core: REFRAC_CYC must be in 1..15");
    end

    logic [AW-1:0]                ptr_q, ptr_d;
    logic [N_NEURONS-1:0][W-1:0]  state_q, state_d;
    logic [N_NEURONS-1:0][W-1:0]  thresh_q, thresh_d;
    logic [N_NEURONS-1:0]         flags_q, flags_d;
    logic [N_NEURONS-1:0]         spike_vec_q, spike_vec_d;
    logic                         spike_valid_q, spike_valid_d;
    logic                         spike_q, spike_d;
    logic [AW-1:0]                spike_id_q, spike_id_d;
    logic [W-1:0]                 state_out_q, state_out_d;
    logic                         frame_done_q, frame_done_d;

    logic                         accept_s;
    logic [W:0]                   sum_s;
    logic [W-1:0]                 next_sat_s;
    logic                         fire_s;
    logic [W-1:0]                 new_state_s;
    logic [N_NEURONS-1:0]         frame_s;
    logic                         in_refrac_s;

    assign in_ready = ~cfg_we;
    assign accept_s = in_valid & ~cfg_we;

`ifdef TM_LIF_REFRACTORY_EN
    logic [N_NEURONS-1:0][3:0]    refrac_q, refrac_d;

    assign in_refrac_s = (refrac_q[ptr_q] != 4'd0);

    // Refractory counters: load on fire, count down on each visit while nonzero.
    always_comb begin
        refrac_d = refrac_q;
        if (accept_s && in_refrac_s) begin
            refrac_d[ptr_q] = refrac_q[ptr_q] - 4'd1;
        end else if (accept_s && fire_s) begin
            refrac_d[ptr_q] = 4'(REFRAC_CYC);
        end else begin
            refrac_d = refrac_q;
        end
    end

    // Refractory counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refrac_q <= '0;
        end else begin
            refrac_q <= refrac_d;
        end
    end
`else
    assign in_refrac_s = 1'b0;
`endif

    // Membrane update for the neuron at ptr: leak, integrate, saturate, threshold.
    always_comb begin
        sum_s      = {1'b0, in_current} + ({1'b0, state_q[ptr_q]} >> LEAK_SHIFT);
        next_sat_s = sum_s[W] ? {W{1'b1}} : sum_s[W-1:0];
        if (in_refrac_s) begin
            fire_s      = 1'b0;
            new_state_s = {W{1'b0}};
        end else if (next_sat_s >= thresh_q[ptr_q]) begin
            fire_s      = 1'b1;
            new_state_s = {W{1'b0}};
        end else begin
            fire_s      = 1'b0;
            new_state_s = next_sat_s;
        end
        frame_s        = flags_q;
        frame_s[ptr_q] = fire_s;
    end

    // Next-state for pointer, neuron arrays, frame bookkeeping and result outputs.
    always_comb begin
        ptr_d         = ptr_q;
        state_d       = state_q;
        thresh_d      = thresh_q;
        flags_d       = flags_q;
        spike_vec_d   = spike_vec_q;
        spike_valid_d = 1'b0;
        spike_d       = spike_q;
        spike_id_d    = spike_id_q;
        state_out_d   = state_out_q;
        frame_done_d  = 1'b0;

        if (accept_s) begin
            ptr_d          = ptr_q + AW'(1);
            state_d[ptr_q] = new_state_s;
            spike_valid_d  = 1'b1;
            spike_d        = fire_s;
            spike_id_d     = ptr_q;
            state_out_d    = new_state_s;
            if (ptr_q == LAST_IDX) begin
                spike_vec_d  = frame_s;
                flags_d      = '0;
                frame_done_d = 1'b1;
            end else begin
                flags_d = frame_s;
            end
        end else begin
            ptr_d = ptr_q;
        end

        // Accepts and threshold writes are mutually exclusive because in_ready = !cfg_we.
        if (cfg_we) begin
            thresh_d[cfg_addr] = cfg_thresh;
        end else begin
            thresh_d = thresh_q;
        end
    end

    // Core state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            state_q       <= '0;
            thresh_q      <= {N_NEURONS{THRESH_INIT}};
            flags_q       <= '0;
            spike_vec_q   <= '0;
            spike_valid_q <= 1'b0;
            spike_q       <= 1'b0;
            spike_id_q    <= '0;
            state_out_q   <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            state_q       <= state_d;
            thresh_q      <= thresh_d;
            flags_q       <= flags_d;
            spike_vec_q   <= spike_vec_d;
            spike_valid_q <= spike_valid_d;
            spike_q       <= spike_d;
            spike_id_q    <= spike_id_d;
            state_out_q   <= state_out_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike       = spike_q;
    assign spike_id    = spike_id_q;
    assign state_out   = state_out_q;
    assign spike_vec   = spike_vec_q;
    assign frame_done  = frame_done_q;

endmodule

// File: doc/tm_lif_core.md
TM_LIF_CORE -- requirements
Module: tm_lif_core

Interface
REQ-001 Parameter N_NEURONS, default 8: number of time-multiplexed neurons, power of two, 2..64.
REQ-002 Parameter W, default 8: membrane, current and threshold width in bits.
REQ-003 Parameter LEAK_SHIFT, default 1: leak as right-shift of stored state, 0..W-1.
REQ-004 Parameter THRESH_RST, default 127: threshold loaded into every neuron at reset.
REQ-005 Parameter REFRAC_CYC, default 2: refractory length in neuron visits, 1..15.
REQ-006 clk  in  1  clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 in_valid  in  1  in_current is valid for the neuron at ptr.
REQ-009 in_ready  out  1  core accepts in_current this cycle.
REQ-010 in_current  in  W  unsigned input current for neuron ptr.
REQ-011 cfg_we  in  1  threshold write strobe.
REQ-012 cfg_addr  in  log2(N_NEURONS)  neuron index for threshold write.
REQ-013 cfg_thresh  in  W  unsigned threshold value to write.
REQ-014 spike_valid  out  1  one-cycle pulse: update result is valid.
REQ-015 spike  out  1  the updated neuron fired; qualified by spike_valid.
REQ-016 spike_id  out  log2(N_NEURONS)  index of the updated neuron.
REQ-017 state_out  out  W  post-update membrane state of spike_id.
REQ-018 spike_vec  out  N_NEURONS  per-neuron spike flags of the last completed frame.
REQ-019 frame_done  out  1  one-cycle pulse when neuron N_NEURONS-1 is updated.

Function
REQ-020 An accept occurs when in_valid and in_ready are both 1; in_ready SHALL equal NOT cfg_we, combinationally.
REQ-021 Pointer ptr SHALL advance by 1 on every accept, wrap from N_NEURONS-1 to 0, and hold when no accept occurs.
REQ-022 On an accept: next = in_current + (state[ptr] >> LEAK_SHIFT), computed W+1 bits wide and saturated to 2^W-1.
REQ-023 Fire when next >= thresh[ptr]; on fire state[ptr] <= 0, otherwise state[ptr] <= next.
REQ-024 spike_valid, spike, spike_id and state_out SHALL be registered and valid exactly 1 cycle after the accept; spike_valid is 0 in cycles without an accept.
REQ-025 A frame-local flag vector SHALL record the fire of each accept; when ptr wraps, spike_vec SHALL load the complete frame (including the final neuron), frame_done SHALL pulse in the same cycle as that neuron's spike_valid, and the flags SHALL clear.
REQ-026 cfg_we SHALL write thresh[cfg_addr] in 1 cycle; because in_ready is 0 then, no update occurs in that cycle, and the new value applies from the next visit.
REQ-027 in_valid = 0 SHALL leave all state, thresholds and ptr unchanged, with no implicit leak.

Reset
REQ-028 When rst_n = 0 at a clock edge: ptr, every state, frame flags, spike_vec, spike_valid, spike, spike_id, state_out and frame_done SHALL become 0, every thresh SHALL become THRESH_RST, and refractory counters SHALL become 0.
REQ-029 Reset mid-frame SHALL discard the partial frame without a frame_done pulse.

Configuration
REQ-030 With TM_LIF_REFRACTORY_EN defined: each fire loads a 4-bit counter with REFRAC_CYC; while the counter is nonzero, an accept on that neuron decrements it, holds state at 0, ignores in_current and cannot fire, but still produces spike_valid.
REQ-031 Without TM_LIF_REFRACTORY_EN: no counters are built, REFRAC_CYC is ignored, and every accept follows REQ-022/023.

Verification
(All scenarios use N=8, W=8, LEAK_SHIFT=1, THRESH_RST=127.)
REQ-032 Reset, then 8 accepts with current 0 -> spike always 0, state_out 0, frame_done once (on the 8th result), spike_vec 0x00.
REQ-033 Current 64 on every visit of neuron 0 (others 0) -> state_out 64, 96, 112, 120, 124, 126, then spike on the 7th visit with state_out 0 and spike_vec bit0 = 1 for that frame.
REQ-034 cfg_thresh = 255 written to neuron 2, then current 200 on every visit -> visit 1 gives state 200 with no spike; visit 2 saturates to 255 and spikes.
REQ-035 cfg_we with addr 5, thresh 10 while in_valid = 1 -> in_ready 0 that cycle and ptr holds; a later current of 10 at neuron 5 -> spike.
REQ-036 REFRAC_CYC = 2, current 200 on every visit of neuron 1 -> with macro: fire on visits 1 and 4, no spike on visits 2 and 3; without macro: fire on every visit.
REQ-037 rst_n low for 1 cycle at ptr = 3 after cfg writes -> next result reports spike_id 0, all thresholds are 127, spike_vec 0x00, and no frame_done pulse.
